// File: rtl/apb_slave_regs.sv
// apb_slave_regs: APB completer with a bank of DEPTH x DATA_W registers,
// word-aligned decode, pslverr on bad address, optional wait states.
// Ports: pclk, preset (sync, active-high), pselx/penable/pwrite/paddr/pwdata
// in; prdata/pready/pslverr out (all registered).
// Macro APB_SLV_WAIT_EN: when defined, WAIT_CYCLES wait states per transfer
// via a 4-bit down-counter; otherwise every transfer is zero-wait.
module apb_slave_regs #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              pselx,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int MEM_W = $clog2(DEPTH);

`ifdef APB_SLV_WAIT_EN
  localparam logic [3:0] W = 4'(WAIT_CYCLES);
`else
  // Parameter kept legal but has no effect in this build.
  localparam logic [3:0] W = 4'(WAIT_CYCLES & 0);
`endif

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_prdata;
  logic              r_pready;
  logic              r_pslverr;
`ifdef APB_SLV_WAIT_EN
  logic [3:0]        r_wcnt;
`endif

  logic [ADDR_W-1:0] w_addr;
  logic              w_write;
  logic [IDX_W-1:0]  w_idx;
  logic [MEM_W-1:0]  w_slot;
  logic              w_err;
  logic [DATA_W-1:0] w_rd_data;

  // In IDLE the response (zero-wait case) is built from the live bus,
  // which is being latched on the same edge; afterwards from the latch.
  assign w_addr  = (r_state == S_IDLE) ? paddr : r_addr;
  assign w_write = (r_state == S_IDLE) ? pwrite : r_write;
  assign w_idx   = w_addr[ADDR_W-1:2];
  assign w_slot  = w_idx[MEM_W-1:0];
  assign w_err   = (w_addr[1:0] != 2'b00) ||
                   (32'(w_idx) >= 32'(DEPTH));
  assign w_rd_data = (!w_write && !w_err) ? r_mem[w_slot] : '0;

  assign prdata  = r_prdata;
  assign pready  = r_pready;
  assign pslverr = r_pslverr;

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
`ifdef APB_SLV_WAIT_EN
      r_wcnt    <= '0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          // pselx with penable in IDLE is a protocol error: ignored.
          if (pselx && !penable) begin
            r_addr  <= paddr;
            r_write <= pwrite;
            r_wdata <= pwdata;
            r_state <= S_ACCESS;
`ifdef APB_SLV_WAIT_EN
            r_wcnt  <= W;
`endif
            if (W == 4'd0) begin
              r_pready  <= 1'b1;
              r_pslverr <= w_err;
              r_prdata  <= w_rd_data;
            end
          end
        end
        S_ACCESS: begin
          if (r_pready) begin
            if (r_write && !w_err) begin
              r_mem[w_slot] <= r_wdata;
            end
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
            r_state   <= S_IDLE;
          end else if (!pselx) begin
            r_state <= S_IDLE;
          end else begin
`ifdef APB_SLV_WAIT_EN
            r_wcnt <= r_wcnt - 4'd1;
            if (r_wcnt == 4'd1) begin
              r_pready  <= 1'b1;
              r_pslverr <= w_err;
              r_prdata  <= w_rd_data;
            end
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_regs.sv
// tb_apb_slave_regs: directed + random APB transfers against a register-array
// reference model; checks wait count, pslverr, read data and pready pulse.
module tb_apb_slave_regs;

  localparam int WC = 3;
`ifdef APB_SLV_WAIT_EN
  localparam int W = WC;
`else
  localparam int W = 0;
`endif

  logic        pclk = 1'b0;
  logic        preset;
  logic        pselx;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  apb_slave_regs #(
    .ADDR_W(8),
    .DATA_W(32),
    .DEPTH(16),
    .WAIT_CYCLES(WC)
  ) dut (
    .pclk(pclk),
    .preset(preset),
    .pselx(pselx),
    .penable(penable),
    .pwrite(pwrite),
    .paddr(paddr),
    .pwdata(pwdata),
    .prdata(prdata),
    .pready(pready),
    .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge pclk) cyc++;

  logic [31:0] model [16];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_err(logic [7:0] a);
    return (a[1:0] != 2'b00) || (int'(a[7:2]) >= 16);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
  endtask

  // One complete transfer; returns at completion edge + 1 with bus idle,
  // so a following call starts its setup with no gap.
  task automatic xfer(string tag, logic [7:0] a, bit wr, logic [31:0] wd);
    int waits;
    bit e;
    logic [31:0] exp_rd;
    e = is_err(a);
    exp_rd = (!wr && !e) ? model[a[5:2]] : 32'h0;
    pselx = 1'b1; penable = 1'b0;
    paddr = a; pwrite = wr; pwdata = wd;
    @(posedge pclk); #1;
    penable = 1'b1;
    paddr = 8'($urandom);
    pwdata = $urandom;
    waits = 0;
    while (pready !== 1'b1 && waits < 40) begin
      @(posedge pclk); #1;
      paddr = 8'($urandom);
      pwdata = $urandom;
      waits++;
    end
    chk({tag, ".waits"}, 32'(waits), 32'(W));
    chk({tag, ".err"}, 32'(pslverr), 32'(e));
    if (!wr) chk({tag, ".rdata"}, prdata, exp_rd);
    @(posedge pclk); #1;
    if (wr && !e) model[a[5:2]] = wd;
    pselx = 1'b0; penable = 1'b0;
    chk({tag, ".done"}, 32'(pready), 32'h0);
  endtask

  initial begin
    int c0;
    logic [7:0] a;
    preset = 1'b1; pselx = 1'b0; penable = 1'b0;
    pwrite = 1'b0; paddr = '0; pwdata = '0;
    clear_model();
    repeat (2) @(posedge pclk);
    #1;
    preset = 1'b0;
    chk("rst.prdata", prdata, 32'h0);
    chk("rst.pready", 32'(pready), 32'h0);
    chk("rst.pslverr", 32'(pslverr), 32'h0);
    xfer("rst.rd04", 8'h04, 1'b0, 32'h0);

    xfer("wr0c", 8'h0C, 1'b1, 32'hDEADBEEF);
    xfer("rd0c", 8'h0C, 1'b0, 32'h0);
    xfer("wr00", 8'h00, 1'b1, 32'h12345678);
    xfer("rd00", 8'h00, 1'b0, 32'h0);

    xfer("wr04", 8'h04, 1'b1, 32'hCAFEF00D);
    xfer("err40", 8'h40, 1'b1, 32'hFFFFFFFF);
    xfer("err05", 8'h05, 1'b1, 32'hFFFFFFFF);
    xfer("errrd44", 8'h44, 1'b0, 32'h0);
    xfer("errrd06", 8'h06, 1'b0, 32'h0);
    xfer("rd04", 8'h04, 1'b0, 32'h0);

    // pselx+penable while idle must be ignored.
    pselx = 1'b1; penable = 1'b1; pwrite = 1'b1;
    paddr = 8'h04; pwdata = 32'h0BADBAD0;
    @(posedge pclk); #1;
    chk("viol.pready", 32'(pready), 32'h0);
    pselx = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    chk("viol.pready2", 32'(pready), 32'h0);
    xfer("viol.rd04", 8'h04, 1'b0, 32'h0);

`ifdef APB_SLV_WAIT_EN
    xfer("ab.pre", 8'h08, 1'b1, 32'h11112222);
    pselx = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 8'h08; pwdata = 32'hAAAA5555;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    chk("ab.mid", 32'(pready), 32'h0);
    pselx = 1'b0; penable = 1'b0;
    repeat (4) begin
      @(posedge pclk); #1;
      chk("ab.nordy", 32'(pready), 32'h0);
    end
    xfer("ab.rd08", 8'h08, 1'b0, 32'h0);
`endif

    c0 = cyc;
    xfer("b2b.w10", 8'h10, 1'b1, 32'hA5A5A5A5);
    xfer("b2b.w14", 8'h14, 1'b1, 32'h5A5A5A5A);
    xfer("b2b.r10", 8'h10, 1'b0, 32'h0);
    xfer("b2b.r14", 8'h14, 1'b0, 32'h0);
    chk("b2b.cycles", 32'(cyc - c0), 32'(4 * (W + 2)));

    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom_range(0, 8'h4F));
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      xfer($sformatf("rnd%0d", i), a, 1'($urandom), $urandom);
    end

    // Reset during the access phase of a write: write is dropped.
    pselx = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 8'h1C; pwdata = 32'h77778888;
    @(posedge pclk); #1;
    penable = 1'b1;
    preset = 1'b1;
    @(posedge pclk); #1;
    chk("mrst.prdata", prdata, 32'h0);
    chk("mrst.pready", 32'(pready), 32'h0);
    chk("mrst.pslverr", 32'(pslverr), 32'h0);
    preset = 1'b0; pselx = 1'b0; penable = 1'b0;
    clear_model();
    xfer("mrst.rd1c", 8'h1C, 1'b0, 32'h0);
    xfer("mrst.rd0c", 8'h0C, 1'b0, 32'h0);
    xfer("mrst.rd10", 8'h10, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
